// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared defaults, fetch-queue entry type and width helpers for the fetch unit
package if_pkg;
    localparam int ADDR_W_DEFAULT  = 32;
    localparam int INSTR_W_DEFAULT = 32;
    localparam logic [ADDR_W_DEFAULT-1:0] RESET_PC_DEFAULT = '0;

    typedef struct packed {
        logic [ADDR_W_DEFAULT-1:0]  pc;
        logic [INSTR_W_DEFAULT-1:0] instr;
    } fq_entry_t;

    function automatic int pc_step(input int instr_w);
        return instr_w / 8;
    endfunction

    // Counts must represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/if_fetch_unit_if.sv
// rtl/if_fetch_unit_if.sv - redirect, instruction-memory and decode-side signals of the fetch unit
interface if_fetch_unit_if
    import if_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEFAULT,
    parameter int INSTR_W = INSTR_W_DEFAULT
);
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [ADDR_W-1:0]  imem_req_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;
    logic [ADDR_W-1:0]  out_pc4;

    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
        output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc, out_pc4
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
        input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc, out_pc4
    );
endinterface

// File: rtl/if_fetch_fifo.sv
// rtl/if_fetch_fifo.sv - synchronous FIFO with flush, used for the fetch queue and in-flight PC tracking
module if_fetch_fifo
    import if_pkg::*;
#(
    parameter type entry_t = fq_entry_t,
    parameter int  DEPTH   = 2,
    parameter int  CNT_W   = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  entry_t           push_data,
    input  logic             pop,
    output entry_t           head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    entry_t           mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign count   = CNT_W'(wr_ptr - rd_ptr);
    assign head    = mem[rd_ptr[PTR_W-1:0]];
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is accepted when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (PTR_W + 1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (PTR_W + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end
endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch: PC, in-order memory requests, fetch queue towards decode
// Optional IF_PERF_CNT_EN adds perf_fetched / perf_dropped counters.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEFAULT,
    parameter int                INSTR_W  = INSTR_W_DEFAULT,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
    parameter int                FQ_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    if_fetch_unit_if.master bus
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_dropped
`endif
);
    localparam int                CNT_W   = cnt_w(FQ_DEPTH);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(pc_step(INSTR_W));

    typedef logic [ADDR_W-1:0] addr_t;
    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    addr_t            pc;
    logic [CNT_W-1:0] pending;
    logic [CNT_W-1:0] drop;
    logic [CNT_W-1:0] fq_count;
    logic [CNT_W-1:0] pcq_count;
    logic             fq_full, fq_empty, pcq_full, pcq_empty;
    entry_t           fq_head;
    entry_t           fq_push_data;
    addr_t            pcq_head;
    logic             pop_req, pop, req_fire, rsp_keep, rsp_drop, credit_ok;
    logic [CNT_W:0]   occupancy;
    logic [CNT_W:0]   limit;
    logic             unused_fifo_status;

    assign pop_req   = bus.out_valid && bus.out_ready;
    assign pop       = pop_req && !bus.redirect_valid;
    // Queue slots plus in-flight requests form the credit pool; a pop this cycle frees one slot.
    assign occupancy = {1'b0, fq_count} + {1'b0, pending};
    assign limit     = (CNT_W + 1)'(FQ_DEPTH) + {{CNT_W{1'b0}}, pop_req};
    assign credit_ok = occupancy < limit;

    assign bus.imem_req_valid = !rst && !bus.redirect_valid && credit_ok;
    assign bus.imem_req_addr  = pc;
    assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

    assign rsp_keep     = bus.imem_rsp_valid && (drop == '0) && !bus.redirect_valid;
    assign rsp_drop     = bus.imem_rsp_valid && !rsp_keep;
    assign fq_push_data = '{pc: pcq_head, instr: bus.imem_rsp_data};

    assign bus.out_valid = !fq_empty;
    assign bus.out_instr = fq_empty ? '0 : fq_head.instr;
    assign bus.out_pc    = fq_empty ? '0 : fq_head.pc;
    assign bus.out_pc4   = fq_empty ? '0 : fq_head.pc + PC_STEP;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= RESET_PC;
            pending <= '0;
            drop    <= '0;
        end else if (bus.redirect_valid) begin
            // Everything still outstanding after this cycle's response belongs to the old path.
            pc      <= bus.redirect_pc;
            pending <= pending - CNT_W'(bus.imem_rsp_valid);
            drop    <= pending - CNT_W'(bus.imem_rsp_valid);
        end else begin
            if (req_fire) pc <= pc + PC_STEP;
            pending <= pending + CNT_W'(req_fire) - CNT_W'(bus.imem_rsp_valid);
            if (rsp_drop) drop <= drop - CNT_W'(1);
        end
    end

    if_fetch_fifo #(
        .entry_t (addr_t),
        .DEPTH   (FQ_DEPTH)
    ) u_pc_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.redirect_valid),
        .push      (req_fire),
        .push_data (pc),
        .pop       (rsp_keep),
        .head      (pcq_head),
        .count     (pcq_count),
        .full      (pcq_full),
        .empty     (pcq_empty)
    );

    if_fetch_fifo #(
        .entry_t (entry_t),
        .DEPTH   (FQ_DEPTH)
    ) u_fetch_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.redirect_valid),
        .push      (rsp_keep),
        .push_data (fq_push_data),
        .pop       (pop),
        .head      (fq_head),
        .count     (fq_count),
        .full      (fq_full),
        .empty     (fq_empty)
    );

    assign unused_fifo_status = &{1'b0, pcq_count, pcq_full, pcq_empty, fq_full};

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
        end else begin
            if (pop) perf_fetched <= perf_fetched + 32'd1;
            perf_dropped <= perf_dropped + 32'(rsp_drop) +
                            (bus.redirect_valid ? 32'(fq_count) : 32'd0);
        end
    end
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - randomized self-checking bench for if_fetch_unit with a queue-based fetch model
module tb_if_fetch_unit;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    if_fetch_unit_if #(.ADDR_W(32), .INSTR_W(32)) bus ();
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;
`endif

    if_fetch_unit #(
        .ADDR_W(32), .INSTR_W(32), .RESET_PC(RST_PC), .FQ_DEPTH(DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_dropped (perf_dropped)
`endif
    );

    typedef struct {
        int          due;
        logic [31:0] pc;
        logic [31:0] daddr;
        int          epoch;
    } rsp_t;

    int          pass_cnt = 0;
    int          chk_cnt  = 0;
    int          cyc      = 0;
    int          lat      = 1;
    int          last_due = 0;
    int          epoch    = 0;
    logic [31:0] next_pc  = RST_PC;
    logic [31:0] mq[$];
    logic [31:0] popped[$];
    rsp_t        sched[$];
    logic [31:0] m_fetched = 0;
    logic [31:0] m_dropped = 0;

    bit          r_redirect = 0;
    logic [31:0] r_redirect_pc = 0;
    bit          r_out_ready = 0;
    bit          r_req_ready = 0;
    bit          s_req_valid;
    logic [31:0] s_req_addr;
    bit          s_rsp;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    // One clock cycle: drive at negedge, check against the model, then advance the model at posedge.
    task automatic step();
        rsp_t        r;
        logic [31:0] daddr;
        bit          rsp, pop, exp_rv, exp_ov, fire;
        int          due;
        rsp = (sched.size() > 0) && (sched[0].due <= cyc);
        bus.imem_rsp_valid = rsp;
        bus.imem_rsp_data  = 32'h0;
        if (rsp) bus.imem_rsp_data = mem_fn(sched[0].daddr);
        bus.redirect_valid = r_redirect;
        bus.redirect_pc    = r_redirect_pc;
        bus.out_ready      = r_out_ready;
        bus.imem_req_ready = r_req_ready;
        #1;
        exp_ov = mq.size() > 0;
        pop    = exp_ov && r_out_ready;
        exp_rv = !r_redirect && (mq.size() + sched.size() < DEPTH + int'(pop));
        chk_cnt++;
        if (bus.out_valid !== exp_ov) $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, bus.out_valid, exp_ov);
        else pass_cnt++;
        if (exp_ov) begin
            chk_cnt++;
            if (bus.out_pc !== mq[0]) $display("FAIL out_pc cyc=%0d got=%h exp=%h", cyc, bus.out_pc, mq[0]);
            else pass_cnt++;
            chk_cnt++;
            if (bus.out_instr !== mem_fn(mq[0])) $display("FAIL out_instr cyc=%0d got=%h exp=%h", cyc, bus.out_instr, mem_fn(mq[0]));
            else pass_cnt++;
            chk_cnt++;
            if (bus.out_pc4 !== mq[0] + 32'd4) $display("FAIL out_pc4 cyc=%0d got=%h exp=%h", cyc, bus.out_pc4, mq[0] + 32'd4);
            else pass_cnt++;
        end
        chk_cnt++;
        if (bus.imem_req_valid !== exp_rv) $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, bus.imem_req_valid, exp_rv);
        else pass_cnt++;
        if (exp_rv) begin
            chk_cnt++;
            if (bus.imem_req_addr !== next_pc) $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, bus.imem_req_addr, next_pc);
            else pass_cnt++;
        end
`ifdef IF_PERF_CNT_EN
        chk_cnt++;
        if (perf_fetched !== m_fetched) $display("FAIL perf_fetched cyc=%0d got=%0d exp=%0d", cyc, perf_fetched, m_fetched);
        else pass_cnt++;
        chk_cnt++;
        if (perf_dropped !== m_dropped) $display("FAIL perf_dropped cyc=%0d got=%0d exp=%0d", cyc, perf_dropped, m_dropped);
        else pass_cnt++;
`endif
        s_req_valid = bus.imem_req_valid;
        s_req_addr  = bus.imem_req_addr;
        s_rsp       = rsp;
        daddr       = bus.imem_req_addr;
        fire        = exp_rv && r_req_ready;
        @(posedge clk);
        if (rsp) r = sched.pop_front();
        if (r_redirect) begin
            m_dropped += 32'(mq.size()) + 32'(rsp);
            mq.delete();
            epoch++;
            next_pc = r_redirect_pc;
        end else begin
            if (pop) begin
                popped.push_back(mq.pop_front());
                m_fetched++;
            end
            if (rsp) begin
                if (r.epoch != epoch) m_dropped++;
                else mq.push_back(r.pc);
            end
            if (fire) begin
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                sched.push_back('{due, next_pc, daddr, epoch});
                next_pc += 32'd4;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic redirect_to(input logic [31:0] target);
        r_redirect = 1; r_redirect_pc = target;
        step();
        r_redirect = 0;
    endtask

    task automatic test_reset();
        bus.redirect_valid = 0; bus.redirect_pc = 0; bus.imem_req_ready = 0;
        bus.imem_rsp_valid = 0; bus.imem_rsp_data = 0; bus.out_ready = 0;
        rst = 1;
        repeat (3) @(negedge clk);
        chk_cnt++;
        if (bus.out_valid !== 1'b0 || bus.imem_req_valid !== 1'b0)
            $display("FAIL reset_valids got=%b%b exp=00", bus.out_valid, bus.imem_req_valid);
        else pass_cnt++;
        chk_cnt++;
        if ({bus.out_instr, bus.out_pc, bus.out_pc4} !== 96'h0)
            $display("FAIL reset_outs got=%h/%h/%h exp=0", bus.out_instr, bus.out_pc, bus.out_pc4);
        else pass_cnt++;
        rst = 0;
        r_out_ready = 1; r_req_ready = 1; lat = 1;
        step();
        chk_cnt++;
        if (s_req_valid !== 1'b1 || s_req_addr !== 32'h100)
            $display("FAIL first_req got=%b/%h exp=1/00000100", s_req_valid, s_req_addr);
        else pass_cnt++;
    endtask

    task automatic test_stream();
        int n0;
        popped.delete();
        lat = 1; r_out_ready = 1; r_req_ready = 1;
        run(6);
        chk_cnt++;
        if (popped.size() == 0 || popped[0] !== 32'h100)
            $display("FAIL stream_first got=%0d entries exp=first 00000100", popped.size());
        else pass_cnt++;
        n0 = popped.size();
        run(20);
        chk_cnt++;
        if (popped.size() - n0 != 20) $display("FAIL throughput got=%0d exp=20", popped.size() - n0);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int n0;
        bit seq_ok;
        r_out_ready = 0;
        run(10);
        chk_cnt++;
        if (s_req_valid !== 1'b0) $display("FAIL bp_req_valid got=%b exp=0", s_req_valid);
        else pass_cnt++;
        n0 = popped.size();
        r_out_ready = 1;
        run(12);
        chk_cnt++;
        if (popped.size() - n0 != 12) $display("FAIL bp_resume_count got=%0d exp=12", popped.size() - n0);
        else pass_cnt++;
        seq_ok = 1;
        for (int i = (n0 > 0 ? n0 : 1); i < popped.size(); i++)
            if (popped[i] !== popped[i-1] + 32'd4) seq_ok = 0;
        chk_cnt++;
        if (!seq_ok) $display("FAIL bp_resume_seq got=gap_or_dup exp=contiguous");
        else pass_cnt++;
    endtask

    task automatic test_redirect();
        bit found = 0;
        lat = 3; r_out_ready = 0; r_req_ready = 1;
        redirect_to(32'h180);
        for (int i = 0; i < 30 && !found; i++) begin
            if (mq.size() == 1 && sched.size() == 3) found = 1;
            else step();
        end
        chk_cnt++;
        if (!found) $display("FAIL redirect_setup got=q%0d/p%0d exp=q1/p3", mq.size(), sched.size());
        else pass_cnt++;
        redirect_to(32'h200);
        popped.delete();
        r_out_ready = 1;
        run(15);
        chk_cnt++;
        if (popped.size() < 2 || popped[0] !== 32'h200 || popped[1] !== 32'h204)
            $display("FAIL redirect_seq got=%0d entries exp=00000200,00000204", popped.size());
        else pass_cnt++;
    endtask

    task automatic test_redirect_rsp();
        bit found = 0;
        lat = 1; r_out_ready = 1; r_req_ready = 1;
        for (int i = 0; i < 10 && !found; i++) begin
            if (sched.size() > 0 && sched[0].due <= cyc) found = 1;
            else step();
        end
        redirect_to(32'h300);
        chk_cnt++;
        if (!found || !s_rsp || s_req_valid !== 1'b0)
            $display("FAIL redirect_rsp got=rsp%0b/req_valid%0b exp=rsp1/req_valid0", s_rsp, s_req_valid);
        else pass_cnt++;
`ifdef IF_PERF_CNT_EN
        chk_cnt++;
        if (perf_dropped !== m_dropped) $display("FAIL redirect_rsp_dropped got=%0d exp=%0d", perf_dropped, m_dropped);
        else pass_cnt++;
`endif
        popped.delete();
        run(8);
        chk_cnt++;
        if (popped.size() == 0 || popped[0] !== 32'h300)
            $display("FAIL redirect_rsp_next got=%0d entries exp=first 00000300", popped.size());
        else pass_cnt++;
    endtask

    task automatic test_stall_wrap();
        logic [31:0] a0;
        bit          wrap_ok = 0;
        r_req_ready = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 0) a0 = next_pc;
            chk_cnt++;
            if (s_req_valid !== 1'b1 || s_req_addr !== a0)
                $display("FAIL stall_addr cyc=%0d got=%b/%h exp=1/%h", cyc, s_req_valid, s_req_addr, a0);
            else pass_cnt++;
        end
        r_req_ready = 1;
        redirect_to(32'hFFFF_FFF0);
        popped.delete();
        run(14);
        for (int i = 0; i + 1 < popped.size(); i++)
            if (popped[i] == 32'hFFFF_FFFC && popped[i+1] == 32'h0) wrap_ok = 1;
        chk_cnt++;
        if (!wrap_ok) $display("FAIL pc_wrap got=%0d entries exp=FFFFFFFC then 00000000", popped.size());
        else pass_cnt++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 0) lat = $urandom_range(1, 3);
            r_out_ready   = ($urandom_range(0, 3) != 0);
            r_req_ready   = ($urandom_range(0, 3) != 0);
            r_redirect    = ($urandom_range(0, 29) == 0);
            r_redirect_pc = $urandom() & 32'hFFFF_FFFC;
            step();
        end
        r_redirect = 0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_rsp();
        test_stall_wrap();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1);
    end
endmodule
